// File: rtl/wb_master_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the Wishbone master controller:
//   - default ADDR_W / DATA_W / TIMEOUT_CYC values
//   - FSM state encodings (legacy localparams) and the matching state enum
//   - response record (read data + error flag)
//   - helper that folds the TIMEOUT_CYC parameter into the 8-bit counter limit
// -----------------------------------------------------------------------------
package wb_master_pkg;

  localparam int DEF_ADDR_W      = 17;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Legacy-compatible state encodings; the enum below reuses them.
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_BUS  = 2'd1;
  localparam logic [1:0] STATE_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_BUS  = STATE_BUS,
    ST_RESP = STATE_RESP
  } wb_state_e;

  // Response record returned to the command side.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] rd_dat;
    logic                  err;
  } wb_rsp_t;

  // Clamp the timeout parameter into the 8-bit counter range; 0 disables.
  function automatic logic [7:0] tmo_limit(input int cyc);
    logic [7:0] lim;
    if (cyc <= 0) begin
      lim = 8'd0;
    end else if (cyc >= 255) begin
      lim = 8'd255;
    end else begin
      lim = cyc[7:0];
    end
    return lim;
  endfunction

endpackage

// File: rtl/wb_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl_if
// Bundles the command, response and Wishbone bus signals of wb_master_ctrl.
//   master modport : view of the controller (drives cmd_ready, rsp_*, WBs_*)
//   slave  modport : view of the environment (drives cmd_*, rsp_ready,
//                    WBs_RD_DAT, WBs_ACK)
// -----------------------------------------------------------------------------
interface wb_master_ctrl_if
  import wb_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [3:0]        cmd_byte_stb;
  logic [DATA_W-1:0] cmd_wr_dat;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rd_dat;
  logic              rsp_err;

  // Wishbone bus
  logic [ADDR_W-1:0] WBs_ADR;
  logic              WBs_CYC;
  logic              WBs_STB;
  logic              WBs_WE;
  logic              WBs_RD;
  logic [3:0]        WBs_BYTE_STB;
  logic [DATA_W-1:0] WBs_WR_DAT;
  logic [DATA_W-1:0] WBs_RD_DAT;
  logic              WBs_ACK;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_byte_stb, cmd_wr_dat,
    output cmd_ready,
    output rsp_valid, rsp_rd_dat, rsp_err,
    input  rsp_ready,
    output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
    input  WBs_RD_DAT, WBs_ACK
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_byte_stb, cmd_wr_dat,
    input  cmd_ready,
    input  rsp_valid, rsp_rd_dat, rsp_err,
    output rsp_ready,
    input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
    output WBs_RD_DAT, WBs_ACK
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// -----------------------------------------------------------------------------
// wb_timeout_counter
// 8-bit bus-cycle counter. Counts enabled cycles since the last clear and flags
// the cycle in which the count equals limit-1, so an abort taken on that cycle
// ends the bus cycle after exactly 'limit' clocks. limit = 0 never expires.
// Ports:
//   clk, rst   : clock, async active-high reset
//   i_clear    : synchronous clear (takes priority over enable)
//   i_enable   : count this cycle
//   i_limit    : number of cycles allowed
//   o_expired  : this enabled cycle is the last one allowed
// -----------------------------------------------------------------------------
module wb_timeout_counter
  import wb_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_limit,
  output logic       o_expired
);

  logic [7:0] r_count;

  // Cycle counter: cleared outside the bus phase, advances while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = i_enable && (i_limit != 8'd0) && (r_count == (i_limit - 8'd1));

endmodule

// File: rtl/wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl
// Single-outstanding Wishbone master. A command accepted in IDLE is registered
// and driven on the bus from the next cycle; the transaction ends on ACK or on
// timeout, and the response is held in RESP until the consumer takes it.
// Ports:
//   WB_CLK : system clock
//   WB_RST : async active-high reset
//   bus    : wb_master_ctrl_if.master (cmd_*, rsp_*, WBs_* signals)
// Parameters: ADDR_W, DATA_W, TIMEOUT_CYC (1..255 cycles, 0 = no timeout)
// -----------------------------------------------------------------------------
module wb_master_ctrl
  import wb_master_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             WB_CLK,
  input  logic             WB_RST,
  wb_master_ctrl_if.master bus
);

  localparam logic [7:0] TMO_LIMIT = tmo_limit(TIMEOUT_CYC);

  wb_state_e         r_state;
  logic              r_cmd_ready;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic              r_rd;
  logic [ADDR_W-1:0] r_adr;
  logic [3:0]        r_byte_stb;
  logic [DATA_W-1:0] r_wr_dat;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rd_dat;

  logic w_accept;
  logic w_ack;
  logic w_expired;
  logic w_tmo_clear;
  logic w_tmo_enable;

  // r_cmd_ready is low for the first clock after reset, so nothing is taken
  // before the first rising edge following reset release.
  assign w_accept     = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
  // ACK only has meaning inside the bus phase; elsewhere it is ignored.
  assign w_ack        = (r_state == ST_BUS) && bus.WBs_ACK;
  assign w_tmo_enable = (r_state == ST_BUS);
  // Holding the counter clear outside BUS guarantees count 0 on BUS entry.
  assign w_tmo_clear  = (r_state != ST_BUS);

  wb_timeout_counter u_tmo (
    .clk       (WB_CLK),
    .rst       (WB_RST),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_tmo_enable),
    .i_limit   (TMO_LIMIT),
    .o_expired (w_expired)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_rd         <= 1'b0;
      r_adr        <= {ADDR_W{1'b0}};
      r_byte_stb   <= 4'h0;
      r_wr_dat     <= {DATA_W{1'b0}};
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rd_dat <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_BUS;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= bus.cmd_we;
            r_rd        <= ~bus.cmd_we;
            r_adr       <= bus.cmd_adr;
            r_byte_stb  <= bus.cmd_byte_stb;
            r_wr_dat    <= bus.cmd_wr_dat;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_BUS: begin
          // ACK takes priority over a coincident timeout.
          if (w_ack) begin
            r_state      <= ST_RESP;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_rd         <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b0;
            r_rsp_rd_dat <= r_we ? {DATA_W{1'b0}} : bus.WBs_RD_DAT;
          end else if (w_expired) begin
            r_state      <= ST_RESP;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_rd         <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b1;
            r_rsp_rd_dat <= {DATA_W{1'b0}};
          end else begin
            r_state <= ST_BUS;
          end
        end
        ST_RESP: begin
          if (r_rsp_valid && bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a quiet IDLE.
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b0;
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_we        <= 1'b0;
          r_rd        <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_rd_dat   = r_rsp_rd_dat;
  assign bus.WBs_CYC      = r_cyc;
  assign bus.WBs_STB      = r_stb;
  assign bus.WBs_WE       = r_we;
  assign bus.WBs_RD       = r_rd;
  assign bus.WBs_ADR      = r_adr;
  assign bus.WBs_BYTE_STB = r_byte_stb;
  assign bus.WBs_WR_DAT   = r_wr_dat;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_master_ctrl
// Directed bench for wb_master_ctrl (TIMEOUT_CYC = 4). Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_master_ctrl;
  import wb_master_pkg::*;

  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic WB_CLK = 1'b0;
  logic WB_RST;

  int n_checks = 0;
  int n_errors = 0;

  // Values observed during the last bus cycle
  int            obs_cyc;
  int            obs_stb;
  logic          obs_we;
  logic          obs_rd;
  logic [AW-1:0] obs_adr;
  logic [3:0]    obs_bstb;
  logic [DW-1:0] obs_wdat;

  wb_rsp_t exp_rsp;

  wb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_master_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .WB_CLK (WB_CLK),
    .WB_RST (WB_RST),
    .bus    (bus)
  );

  // 10-unit clock
  always #5 WB_CLK = ~WB_CLK;

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Count one comparison, report a mismatch
  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer one command, act as responder (ACK in bus cycle ack_at, -1 = never)
  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [3:0] bstb, input int ack_at, input logic [DW-1:0] rdata);
    int k;
    bus.cmd_valid    = 1'b1;
    bus.cmd_we       = we;
    bus.cmd_adr      = adr;
    bus.cmd_wr_dat   = dat;
    bus.cmd_byte_stb = bstb;
    @(negedge WB_CLK);
    // Accepted: disturb the command inputs, the bus must keep the old ones
    bus.cmd_valid    = 1'b0;
    bus.cmd_we       = ~we;
    bus.cmd_adr      = ~adr;
    bus.cmd_wr_dat   = ~dat;
    bus.cmd_byte_stb = ~bstb;
    obs_cyc  = 0;
    obs_stb  = 0;
    obs_we   = 1'bx;
    obs_rd   = 1'bx;
    obs_adr  = 'x;
    obs_bstb = 'x;
    obs_wdat = 'x;
    k = 0;
    while (bus.WBs_CYC && k < 20) begin
      obs_cyc++;
      if (bus.WBs_STB) obs_stb++;
      obs_we   = bus.WBs_WE;
      obs_rd   = bus.WBs_RD;
      obs_adr  = bus.WBs_ADR;
      obs_bstb = bus.WBs_BYTE_STB;
      obs_wdat = bus.WBs_WR_DAT;
      bus.WBs_RD_DAT = rdata;
      bus.WBs_ACK    = (k == ack_at);
      @(negedge WB_CLK);
      k++;
    end
    bus.WBs_ACK    = 1'b0;
    bus.WBs_RD_DAT = 32'h0BAD_0BAD;
  endtask

  // Consume the pending response and confirm return to IDLE
  task automatic release_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    @(negedge WB_CLK);
    bus.rsp_ready = 1'b0;
    check_val({tag, "_rsp_valid_clr"}, 64'(bus.rsp_valid), 64'd0);
    check_val({tag, "_cmd_ready_set"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    WB_RST           = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_we       = 1'b0;
    bus.cmd_adr      = 17'h0;
    bus.cmd_byte_stb = 4'h0;
    bus.cmd_wr_dat   = 32'h0;
    bus.rsp_ready    = 1'b0;
    bus.WBs_RD_DAT   = 32'h0;
    bus.WBs_ACK      = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge WB_CLK);
    check_val("rst_cyc",       64'(bus.WBs_CYC),      64'd0);
    check_val("rst_stb",       64'(bus.WBs_STB),      64'd0);
    check_val("rst_we_rd",     64'({bus.WBs_WE, bus.WBs_RD}), 64'd0);
    check_val("rst_adr",       64'(bus.WBs_ADR),      64'd0);
    check_val("rst_bstb",      64'(bus.WBs_BYTE_STB), 64'd0);
    check_val("rst_wdat",      64'(bus.WBs_WR_DAT),   64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid),    64'd0);
    check_val("rst_rsp",       64'({bus.rsp_rd_dat, bus.rsp_err}), 64'd0);
    check_val("rst_cmd_ready", 64'(bus.cmd_ready),    64'd0);

    // Release reset with a command already offered: not taken on that edge
    bus.cmd_valid = 1'b1;
    bus.cmd_adr   = 17'h0_0100;
    WB_RST        = 1'b0;
    #1;
    check_val("rel_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge WB_CLK);
    bus.cmd_valid = 1'b0;
    check_val("rel_no_accept", 64'(bus.WBs_CYC),   64'd0);
    check_val("rel_idle_rdy",  64'(bus.cmd_ready), 64'd1);

    // ---- stray ACK in IDLE ----
    for (int i = 0; i < 2; i++) begin
      bus.WBs_ACK    = 1'b1;
      bus.WBs_RD_DAT = 32'h5555_AAAA;
      @(negedge WB_CLK);
      check_val("idle_ack_cyc",   64'(bus.WBs_CYC),   64'd0);
      check_val("idle_ack_valid", 64'(bus.rsp_valid), 64'd0);
      check_val("idle_ack_dat",   64'(bus.rsp_rd_dat), 64'd0);
      check_val("idle_ack_rdy",   64'(bus.cmd_ready), 64'd1);
    end
    bus.WBs_ACK = 1'b0;

    // ---- write, ACK in third bus cycle ----
    run_cmd(1'b1, 17'h0_0004, 32'hA5A5_0001, 4'hF, 2, 32'h1234_5678);
    check_val("wr_cyc_len",  64'(obs_cyc),  64'd3);
    check_val("wr_stb_len",  64'(obs_stb),  64'd3);
    check_val("wr_we",       64'(obs_we),   64'd1);
    check_val("wr_rd",       64'(obs_rd),   64'd0);
    check_val("wr_adr",      64'(obs_adr),  64'h0_0004);
    check_val("wr_bstb",     64'(obs_bstb), 64'hF);
    check_val("wr_wdat",     64'(obs_wdat), 64'hA5A5_0001);
    check_val("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_val("wr_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    exp_rsp = '{rd_dat: 32'h0, err: 1'b0};
    check_val("wr_rsp", 64'({bus.rsp_rd_dat, bus.rsp_err}), 64'(exp_rsp));
    release_rsp("wr");

    // ---- read, ACK in first bus cycle ----
    run_cmd(1'b0, 17'h0_0008, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
    check_val("rd_cyc_len", 64'(obs_cyc), 64'd1);
    check_val("rd_rd",      64'(obs_rd),  64'd1);
    check_val("rd_we",      64'(obs_we),  64'd0);
    check_val("rd_adr",     64'(obs_adr), 64'h0_0008);
    check_val("rd_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    exp_rsp = '{rd_dat: 32'hDEAD_BEEF, err: 1'b0};
    check_val("rd_rsp", 64'({bus.rsp_rd_dat, bus.rsp_err}), 64'(exp_rsp));

    // ---- backpressure with stray ACKs and a new command offered ----
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_we     = 1'b1;
      bus.cmd_adr    = 17'h0_001F;
      bus.WBs_ACK    = (i % 2 == 0);
      bus.WBs_RD_DAT = 32'h3000_0000 + 32'(i);
      @(negedge WB_CLK);
      check_val("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check_val("bp_rsp",   64'({bus.rsp_rd_dat, bus.rsp_err}), 64'(exp_rsp));
      check_val("bp_rdy",   64'(bus.cmd_ready), 64'd0);
      check_val("bp_cyc",   64'(bus.WBs_CYC),   64'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.WBs_ACK   = 1'b0;
    release_rsp("bp");

    // ---- timeout, no ACK ----
    run_cmd(1'b0, 17'h1_0010, 32'h0, 4'h3, -1, 32'h7777_7777);
    check_val("to_cyc_len", 64'(obs_cyc), 64'd4);
    check_val("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    exp_rsp = '{rd_dat: 32'h0, err: 1'b1};
    check_val("to_rsp", 64'({bus.rsp_rd_dat, bus.rsp_err}), 64'(exp_rsp));
    release_rsp("to");

    // ---- ACK on the timeout cycle wins ----
    run_cmd(1'b0, 17'h0_0020, 32'h0, 4'hF, 3, 32'h1357_9BDF);
    check_val("toack_cyc_len", 64'(obs_cyc), 64'd4);
    exp_rsp = '{rd_dat: 32'h1357_9BDF, err: 1'b0};
    check_val("toack_rsp", 64'({bus.rsp_rd_dat, bus.rsp_err}), 64'(exp_rsp));
    release_rsp("toack");

    // ---- reset during second bus cycle ----
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 17'h0_0040;
    @(negedge WB_CLK);
    bus.cmd_valid = 1'b0;
    check_val("mr_cyc1", 64'(bus.WBs_CYC), 64'd1);
    @(negedge WB_CLK);
    check_val("mr_cyc2", 64'(bus.WBs_CYC), 64'd1);
    WB_RST = 1'b1;
    #1;
    check_val("mr_strobes", 64'({bus.WBs_CYC, bus.WBs_STB, bus.WBs_WE, bus.WBs_RD}), 64'd0);
    check_val("mr_adr",     64'(bus.WBs_ADR),   64'd0);
    check_val("mr_valid",   64'(bus.rsp_valid), 64'd0);
    check_val("mr_rdy",     64'(bus.cmd_ready), 64'd0);
    @(negedge WB_CLK);
    WB_RST = 1'b0;
    @(negedge WB_CLK);
    check_val("mr_rdy_after", 64'(bus.cmd_ready), 64'd1);
    run_cmd(1'b0, 17'h0_0044, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
    check_val("mr_rd_cyc_len", 64'(obs_cyc), 64'd2);
    exp_rsp = '{rd_dat: 32'hCAFE_F00D, err: 1'b0};
    check_val("mr_rd_rsp", 64'({bus.rsp_rd_dat, bus.rsp_err}), 64'(exp_rsp));
    release_rsp("mr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
